// File: rtl/ydm_pkg.sv
// Shared types and constants for the ydm memory stage.
package ydm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ydm_align.sv
// Byte-lane steering for stores, load extraction/extension, and
// access legality (misalignment, unsupported funct3) checks.
module ydm_align
  import ydm_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] loadData_o,
  output logic        misalign_o,
  output logic        badLoad_o,
  output logic        badStore_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = rdata_i[{addrLo_i, 3'b000} +: 8];
  assign halfSel = addrLo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Unsigned variants have no store counterpart, so they are store-illegal.
  always_comb begin
    wstrb_o    = 4'b0000;
    wdata_o    = rd2_i;
    loadData_o = 32'h0;
    misalign_o = 1'b0;
    badLoad_o  = 1'b0;
    badStore_o = 1'b0;
    case (funct3_i)
      F3_B: begin
        loadData_o = {{24{byteSel[7]}}, byteSel};
        wstrb_o    = 4'b0001 << addrLo_i;
        wdata_o    = {4{rd2_i[7:0]}};
      end
      F3_H: begin
        loadData_o = {{16{halfSel[15]}}, halfSel};
        wstrb_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{rd2_i[15:0]}};
        misalign_o = addrLo_i[0];
      end
      F3_W: begin
        loadData_o = rdata_i;
        wstrb_o    = 4'b1111;
        misalign_o = |addrLo_i;
      end
      F3_BU: begin
        loadData_o = {24'h0, byteSel};
        badStore_o = 1'b1;
      end
      F3_HU: begin
        loadData_o = {16'h0, halfSel};
        misalign_o = addrLo_i[0];
        badStore_o = 1'b1;
      end
      default: begin
        badLoad_o  = 1'b1;
        badStore_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ydm_stage.sv
// RV32 MEM stage: accepts an EX result, performs an optional load/store over
// a ready/ack memory port, and presents a handshaked write-back packet.
module ydm_stage
  import ydm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_z,
  input  logic [31:0] ex_rd2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        wb_fault
);

  localparam bit              TIMEOUT_EN  = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);

  state_e             state_q, state_d;
  logic [31:0]        z_q, z_d;
  logic [31:0]        rd2_q, rd2_d;
  logic [4:0]         rd_q, rd_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q, memread_d;
  logic               memwrite_q, memwrite_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        wbData_q, wbData_d;
  logic               wbRegwrite_q, wbRegwrite_d;
  logic               wbFault_q, wbFault_d;

  logic        inIdle, inAccess;
  logic [2:0]  alignF3;
  logic [1:0]  alignLo;
  logic [3:0]  alignStrb;
  logic [31:0] alignWdata, alignLoad;
  logic        misalign, badLoad, badStore, issueFault;

  assign inIdle   = (state_q == IDLE);
  assign inAccess = (state_q == ACCESS);

  // In IDLE the checker looks at the incoming request; afterwards at the latched one.
  assign alignF3 = inIdle ? ex_funct3 : funct3_q;
  assign alignLo = inIdle ? ex_z[1:0] : z_q[1:0];

  ydm_align u_align (
    .funct3_i   (alignF3),
    .addrLo_i   (alignLo),
    .rd2_i      (rd2_q),
    .rdata_i    (mem_rdata),
    .wstrb_o    (alignStrb),
    .wdata_o    (alignWdata),
    .loadData_o (alignLoad),
    .misalign_o (misalign),
    .badLoad_o  (badLoad),
    .badStore_o (badStore)
  );

  assign issueFault = (ex_memread & ex_memwrite)
                    | (ex_memread  & (badLoad  | misalign))
                    | (ex_memwrite & (badStore | misalign));

  always_comb begin
    state_d      = state_q;
    z_d          = z_q;
    rd2_d        = rd2_q;
    rd_d         = rd_q;
    regwrite_d   = regwrite_q;
    memread_d    = memread_q;
    memwrite_d   = memwrite_q;
    funct3_d     = funct3_q;
    cnt_d        = cnt_q;
    wbData_d     = wbData_q;
    wbRegwrite_d = wbRegwrite_q;
    wbFault_d    = wbFault_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          z_d        = ex_z;
          rd2_d      = ex_rd2;
          rd_d       = ex_rd;
          regwrite_d = ex_regwrite;
          memread_d  = ex_memread;
          memwrite_d = ex_memwrite;
          funct3_d   = ex_funct3;
          if (!ex_memread && !ex_memwrite) begin
            wbData_d     = ex_z;
            wbRegwrite_d = ex_regwrite;
            wbFault_d    = 1'b0;
            state_d      = RESP;
          end else if (issueFault) begin
            wbData_d     = 32'h0;
            wbRegwrite_d = 1'b0;
            wbFault_d    = 1'b1;
            state_d      = RESP;
          end else begin
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          wbData_d     = memread_q ? alignLoad : 32'h0;
          wbRegwrite_d = memread_q & regwrite_q;
          wbFault_d    = 1'b0;
          state_d      = RESP;
        end else if (TIMEOUT_EN && ((cnt_q + 1'b1) == TIMEOUT_CNT)) begin
          wbData_d     = 32'h0;
          wbRegwrite_d = 1'b0;
          wbFault_d    = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      z_q          <= 32'h0;
      rd2_q        <= 32'h0;
      rd_q         <= 5'h0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      funct3_q     <= 3'h0;
      cnt_q        <= '0;
      wbData_q     <= 32'h0;
      wbRegwrite_q <= 1'b0;
      wbFault_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      z_q          <= z_d;
      rd2_q        <= rd2_d;
      rd_q         <= rd_d;
      regwrite_q   <= regwrite_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      funct3_q     <= funct3_d;
      cnt_q        <= cnt_d;
      wbData_q     <= wbData_d;
      wbRegwrite_q <= wbRegwrite_d;
      wbFault_q    <= wbFault_d;
    end
  end

  // Memory port is driven purely from latched state, so it stays stable through ACCESS.
  assign ex_ready    = inIdle;
  assign mem_req     = inAccess;
  assign mem_we      = inAccess & memwrite_q;
  assign mem_addr    = inAccess ? {z_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata   = (inAccess & memwrite_q) ? alignWdata : 32'h0;
  assign mem_wstrb   = (inAccess & memwrite_q) ? alignStrb : 4'b0000;
  assign wb_valid    = (state_q == RESP);
  assign wb_data     = wbData_q;
  assign wb_rd       = rd_q;
  assign wb_regwrite = wbRegwrite_q;
  assign wb_fault    = wbFault_q;

endmodule
